// File: rtl/rr_arb_mux.sv
// rr_arb_mux
//   Registered N-way multiplexer with valid/ready handshakes. Each cycle the
//   output register can be (re)loaded, one requesting channel is picked,
//   either round-robin from a rotating pointer or by an explicit select. The
//   chosen word is held in a single-entry output register until the consumer
//   takes it.
//
// Parameters
//   N        data width of every channel and of out_data
//   CHANNELS number of input channels (>= 2, any value)
//   S_WIDTH  width of s / out_sel (derived from CHANNELS)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   mode       0 = round-robin, 1 = fixed select by s
//   s          channel select used in mode 1
//   in_valid   per-channel request
//   in_data    flattened channel data, channel i at [i*N +: N]
//   in_ready   one-hot (or zero) accept strobe for the granted channel
//   out_valid  output register holds a word
//   out_data   registered data word
//   out_sel    channel index the held word came from
//   out_ready  consumer accepts out_data this cycle

module rr_arb_mux #(
  parameter int N        = 32,
  parameter int CHANNELS = 32,
  parameter int S_WIDTH  = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [S_WIDTH-1:0]    s,
  input  logic [CHANNELS-1:0]   in_valid,
  input  logic [CHANNELS*N-1:0] in_data,
  output logic [CHANNELS-1:0]   in_ready,
  output logic                  out_valid,
  output logic [N-1:0]          out_data,
  output logic [S_WIDTH-1:0]    out_sel,
  input  logic                  out_ready
);

  logic               load;
  logic               grant_found;
  logic [S_WIDTH-1:0] grant;
  logic [S_WIDTH-1:0] ptr;
  logic [S_WIDTH-1:0] ptr_next;
  logic [S_WIDTH-1:0] scan_idx;
  logic [N-1:0]       grant_data;
  int                 idx;

  always_comb begin
    load        = ~out_valid | out_ready;
    grant_found = 1'b0;
    grant       = '0;
    idx         = 0;
    scan_idx    = '0;

    if (!mode) begin
      // Scan from ptr upward; the wrap is explicit so a non-power-of-two
      // channel count never produces an index >= CHANNELS.
      for (int k = 0; k < CHANNELS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        scan_idx = S_WIDTH'(idx);
        if (!grant_found && in_valid[scan_idx]) begin
          grant_found = 1'b1;
          grant       = scan_idx;
        end
      end
    end else if (int'(s) < CHANNELS) begin
      if (in_valid[s]) begin
        grant_found = 1'b1;
        grant       = s;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == S_WIDTH'(i)) grant_data = in_data[i*N +: N];
    end
  end

  always_comb begin
    ptr_next = (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
  end

  // No transfer may complete while reset is asserted, so the strobe is
  // masked by rst as well as by load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst && load && grant_found && grant == S_WIDTH'(i)) in_ready[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        ptr       <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux: a 32-channel instance and a 20-channel instance
// share the same stimulus and are compared against a per-instance reference
// model computed from the arbitration rules with modulo arithmetic.

module tb_rr_arb_mux;

  localparam int C1 = 32;
  localparam int C2 = 20;
  localparam int N  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            mode;
  logic [4:0]      s;
  logic [C1-1:0]   in_valid;
  logic [C1*N-1:0] in_data;
  logic            out_ready;

  logic [C1-1:0]   in_ready;
  logic            out_valid;
  logic [N-1:0]    out_data;
  logic [4:0]      out_sel;

  logic [C2-1:0]   in_ready2;
  logic            out_valid2;
  logic [N-1:0]    out_data2;
  logic [4:0]      out_sel2;

  rr_arb_mux #(.N(N), .CHANNELS(C1)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .s(s),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  rr_arb_mux #(.N(N), .CHANNELS(C2)) u_dut20 (
    .clk(clk), .rst(rst), .mode(mode), .s(s),
    .in_valid(in_valid[C2-1:0]), .in_data(in_data[C2*N-1:0]), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_sel(out_sel2),
    .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = 32-channel, 1 = 20-channel instance.
  int          mc[2] = '{C1, C2};
  bit          mv[2];
  logic [31:0] md[2];
  int          ms[2];
  int          mp[2];
  logic [31:0] exp_rdy[2];
  logic [31:0] act_rdy[2];

  function automatic int ref_grant(int inst);
    int c;
    c = mc[inst];
    if (mv[inst] && !out_ready) return -1;
    if (!mode) begin
      for (int k = 0; k < c; k++) begin
        int i;
        i = (mp[inst] + k) % c;
        if (in_valid[i]) return i;
      end
      return -1;
    end
    if (int'(s) < c && in_valid[s]) return int'(s);
    return -1;
  endfunction

  // One clock cycle: sample in_ready mid-cycle, predict, advance the model
  // on the edge, return 1 time unit after the edge.
  task automatic tick();
    int g[2];
    @(negedge clk);
    act_rdy[0] = in_ready;
    act_rdy[1] = {12'b0, in_ready2};
    for (int n = 0; n < 2; n++) begin
      g[n] = rst ? -1 : ref_grant(n);
      exp_rdy[n] = (g[n] >= 0) ? (32'd1 << g[n]) : 32'd0;
    end
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        mv[n] = 1'b0; md[n] = '0; ms[n] = 0; mp[n] = 0;
      end else if (!mv[n] || out_ready) begin
        if (g[n] >= 0) begin
          mv[n] = 1'b1;
          md[n] = in_data[g[n]*N +: N];
          ms[n] = g[n];
          mp[n] = (g[n] + 1) % mc[n];
        end else begin
          mv[n] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic set_pattern();
    for (int i = 0; i < C1; i++) in_data[i*N +: N] = 32'hA000_0000 + i;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = '1; mode = 1'b0; s = '0; out_ready = 1'b1; set_pattern();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({out_valid, out_sel, out_data} !== 38'd0) begin
      errors++;
      $display("FAIL reset_out got v=%b sel=%0d data=%h exp 0/0/0", out_valid, out_sel, out_data);
    end
    checks++;
    if (act_rdy[0] !== 32'd0 || act_rdy[1] !== 32'd0) begin
      errors++;
      $display("FAIL reset_ready got %h/%h exp 0/0", act_rdy[0], act_rdy[1]);
    end
    checks++;
    if ({out_valid2, out_sel2, out_data2} !== 38'd0) begin
      errors++;
      $display("FAIL reset_out20 got v=%b sel=%0d data=%h exp 0", out_valid2, out_sel2, out_data2);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 5'd0 || act_rdy[0] !== 32'd1) begin
      errors++;
      $display("FAIL reset_first_grant got v=%b sel=%0d rdy=%h exp 1/0/1", out_valid, out_sel, act_rdy[0]);
    end
    checks++;
    if (out_valid2 !== 1'b1 || out_sel2 !== 5'd0) begin
      errors++;
      $display("FAIL reset_first_grant20 got v=%b sel=%0d exp 1/0", out_valid2, out_sel2);
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    mode = 1'b0; in_valid = '1; out_ready = 1'b1; set_pattern();
    for (int k = 0; k < 34; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 5'(k % 32) ||
          out_data !== 32'hA000_0000 + 32'(k % 32) || act_rdy[0] !== (32'd1 << (k % 32))) begin
        errors++;
        $display("FAIL rr_wrap k=%0d got v=%b sel=%0d data=%h rdy=%h exp sel=%0d", k,
                 out_valid, out_sel, out_data, act_rdy[0], k % 32);
      end
      checks++;
      if (out_sel2 !== 5'(k % 20) || out_data2 !== 32'hA000_0000 + 32'(k % 20) ||
          act_rdy[1] !== exp_rdy[1]) begin
        errors++;
        $display("FAIL rr_wrap20 k=%0d got sel=%0d data=%h rdy=%h exp sel=%0d rdy=%h", k,
                 out_sel2, out_data2, act_rdy[1], k % 20, exp_rdy[1]);
      end
    end
  endtask

  task automatic test_sparse();
    int seq[4] = '{5, 30, 5, 30};
    do_reset();
    mode = 1'b0; out_ready = 1'b1;
    in_valid = (32'd1 << 5) | (32'd1 << 30);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (out_sel !== 5'(seq[k]) || act_rdy[0] !== (32'd1 << seq[k])) begin
        errors++;
        $display("FAIL sparse k=%0d got sel=%0d rdy=%h exp sel=%0d", k, out_sel, act_rdy[0], seq[k]);
      end
      checks++;
      if (out_sel2 !== 5'd5 || act_rdy[1] !== 32'd32) begin
        errors++;
        $display("FAIL sparse20 k=%0d got sel=%0d rdy=%h exp sel=5 rdy=20", k, out_sel2, act_rdy[1]);
      end
    end
  endtask

  task automatic test_fixed_select();
    do_reset();
    mode = 1'b1; s = 5'd7; out_ready = 1'b1;
    in_valid = 32'd1 << 7;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 5'd7 || act_rdy[0] !== 32'h80) begin
      errors++;
      $display("FAIL fixed_hit got v=%b sel=%0d rdy=%h exp 1/7/80", out_valid, out_sel, act_rdy[0]);
    end
    in_valid = ~(32'd1 << 7);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_sel !== 5'd7 || act_rdy[0] !== 32'd0) begin
      errors++;
      $display("FAIL fixed_miss got v=%b sel=%0d rdy=%h exp 0/7/0", out_valid, out_sel, act_rdy[0]);
    end
    s = 5'd25; in_valid = '1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid2 !== 1'b0 || act_rdy[1] !== 32'd0) begin
        errors++;
        $display("FAIL fixed_out_of_range20 k=%0d got v=%b rdy=%h exp 0/0", k, out_valid2, act_rdy[1]);
      end
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 5'd25) begin
        errors++;
        $display("FAIL fixed_25 k=%0d got v=%b sel=%0d exp 1/25", k, out_valid, out_sel);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; out_ready = 1'b1; set_pattern();
    in_valid = 32'd1 << 3;
    tick();
    out_ready = 1'b0; in_valid = '1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 5'd3, 32'hA000_0003} ||
          act_rdy[0] !== 32'd0 || act_rdy[1] !== 32'd0) begin
        errors++;
        $display("FAIL backpressure k=%0d got v=%b sel=%0d data=%h rdy=%h/%h exp 1/3/a0000003/0", k,
                 out_valid, out_sel, out_data, act_rdy[0], act_rdy[1]);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_sel !== 5'd4 || out_data !== 32'hA000_0004 || act_rdy[0] !== 32'h10) begin
      errors++;
      $display("FAIL backpressure_release got sel=%0d data=%h rdy=%h exp 4/a0000004/10",
               out_sel, out_data, act_rdy[0]);
    end
    checks++;
    if (out_sel2 !== 5'd4 || act_rdy[1] !== 32'h10) begin
      errors++;
      $display("FAIL backpressure_release20 got sel=%0d rdy=%h exp 4/10", out_sel2, act_rdy[1]);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; s = 5'd9; in_valid = '1; out_ready = 1'b1;
    tick();
    checks++;
    if (out_sel !== 5'd9) begin
      errors++;
      $display("FAIL mode_fixed9 got sel=%0d exp 9", out_sel);
    end
    mode = 1'b0;
    tick();
    checks++;
    if (out_sel !== 5'd10 || out_sel2 !== 5'd10) begin
      errors++;
      $display("FAIL mode_switch got sel=%0d/%0d exp 10/10", out_sel, out_sel2);
    end
    out_ready = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_valid2 !== 1'b0 || act_rdy[0] !== 32'd0) begin
      errors++;
      $display("FAIL midop_reset got v=%b/%b rdy=%h exp 0/0/0", out_valid, out_valid2, act_rdy[0]);
    end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 5'd0) begin
      errors++;
      $display("FAIL midop_reset_ptr got v=%b sel=%0d exp 1/0", out_valid, out_sel);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom & $urandom);
      mode      = ($urandom_range(0, 3) == 0);
      s         = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 60) == 0);
      for (int j = 0; j < 2; j++) in_data[$urandom_range(0, C1-1)*N +: N] = $urandom;
      tick();
      checks++;
      if ({out_valid, out_sel, out_data} !== {mv[0], 5'(ms[0]), md[0]} || act_rdy[0] !== exp_rdy[0]) begin
        errors++;
        $display("FAIL random32 k=%0d got v=%b sel=%0d data=%h rdy=%h exp v=%b sel=%0d data=%h rdy=%h",
                 k, out_valid, out_sel, out_data, act_rdy[0], mv[0], ms[0], md[0], exp_rdy[0]);
      end
      checks++;
      if ({out_valid2, out_sel2, out_data2} !== {mv[1], 5'(ms[1]), md[1]} || act_rdy[1] !== exp_rdy[1]) begin
        errors++;
        $display("FAIL random20 k=%0d got v=%b sel=%0d data=%h rdy=%h exp v=%b sel=%0d data=%h rdy=%h",
                 k, out_valid2, out_sel2, out_data2, act_rdy[1], mv[1], ms[1], md[1], exp_rdy[1]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; s = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_rr_wrap();
    test_sparse();
    test_fixed_select();
    test_backpressure();
    test_mode_switch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised, registered N-way multiplexer with valid/ready handshakes. It replaces the fixed-tree combinational muxes wherever several producers share one consumer. Each cycle it picks one requesting channel, either round-robin or by an explicit select. The chosen word is captured into a single-entry output register that is held until the consumer accepts it. It sits between multiple register-file/ALU result sources and a single writeback or bus port.

## Interface
Parameters:
- N, 32, data width of every channel and of out_data
- CHANNELS, 32, number of input channels (>= 2; need not be a power of two)
- S_WIDTH, $clog2(CHANNELS), width of s and out_sel (derived; not overridden)

Ports:
- clk  input  1  the single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = round-robin arbitration, 1 = fixed select by s
- s  input  S_WIDTH  channel select used when mode = 1
- in_valid  input  CHANNELS  per-channel request; bit i = channel i has data
- in_data  input  CHANNELS*N  flattened data; channel i occupies bits [i*N +: N]
- in_ready  output  CHANNELS  one-hot or zero; bit i = channel i's word is taken this cycle
- out_valid  output  1  output register holds a word
- out_data  output  N  registered data word
- out_sel  output  S_WIDTH  index of the channel that out_data came from
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid[i] & in_ready[i].
  - An output transfer occurs when out_valid & out_ready.
- load = ~out_valid | out_ready. The register is empty, or it is being drained this cycle.
- Grant, combinational, evaluated only when load = 1:
  - mode 0: the first i with in_valid[i] = 1, scanning from ptr upward and wrapping CHANNELS-1 -> 0.
  - mode 1: grant = s if s < CHANNELS and in_valid[s] = 1; otherwise no grant. Other channels' requests are ignored.
- in_ready[grant] = 1 only when load = 1 and a grant exists. All other bits are 0. in_ready never depends on out_valid alone while load = 0.
- On the clock edge, with load = 1:
  - If a grant exists: out_data <= in_data[grant], out_sel <= grant, out_valid <= 1, ptr <= (grant + 1) mod CHANNELS.
  - If no grant exists: out_valid <= 0. out_data and out_sel hold their last values.
- On the clock edge, with load = 0: all state holds. out_data, out_sel and out_valid stay stable until accepted.
- ptr updates on every grant, in both modes. When the bench switches back to mode 0, scanning resumes after the last granted channel.
- A mode or s change takes effect on the next grant decision. A word already in the output register is unaffected.
- ptr is an S_WIDTH register. Wrap is explicit at CHANNELS-1, so non-power-of-two values never reach an index >= CHANNELS.

## Timing
- Reset values (rst = 1 at a rising edge):
  - out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
  - in_ready = 0 during the reset cycle.
- Reset mid-operation discards any held word. No transfer completes in a cycle where rst = 1.
- Latency: an input accepted at edge k appears on out_data/out_valid after edge k, i.e. 1 cycle.
- Throughput:
  - One word per cycle when out_ready stays high, because drain and load happen in the same cycle.
  - When out_ready = 0 and out_valid = 1, in_ready is all zero (backpressure).
- Fairness: in mode 0, with all channels continuously valid and out_ready = 1, each channel is granted exactly once every CHANNELS cycles.
- in_ready is combinational from in_valid, mode, s, out_valid, out_ready and ptr. The output data and out_valid path is fully registered.

## Test plan
- Reset: assert rst for 2 cycles with all in_valid = 1.
  - -> out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0.
  - -> The first grant after reset release is channel 0.
- Round-robin wrap (CHANNELS = 32, N = 32):
  - Stimulus: all in_valid = 1, in_data[i] = 32'hA000_0000 + i, out_ready = 1, mode 0, run 34 cycles.
  - -> out_sel sequence is 0, 1, …, 31, 0, 1.
  - -> out_data matches out_sel every cycle.
- Sparse requests, ptr = 0:
  - Stimulus: in_valid only on channels 5 and 30.
  - -> Grants alternate 5, 30, 5, 30.
  - -> in_ready is one-hot on the granted bit each cycle.
- Fixed select:
  - mode 1, s = 7, in_valid[7] = 1 → out_sel = 7.
  - s = 7 with in_valid[7] = 0 and others valid → no grant and out_valid drops to 0.
  - CHANNELS = 20 with s = 25 → never a grant.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles after a word from channel 3 is loaded.
  - -> out_data and out_sel = 3 stay stable and in_ready = 0 throughout.
  - -> After out_ready rises, the next channel (4 if valid) loads in the same cycle.
- Mode switch and mid-op reset:
  - Stimulus: grant channel 9 in mode 1, then switch to mode 0 with all valid.
  - -> The next grant is channel 10.
  - Pulse rst while out_valid = 1 → out_valid = 0 next cycle and ptr = 0.
